// File: rtl/pong_engine.sv
// pong_engine: two-player pong core with serve/point/game-over sequencing and LED scan output
// Ports:
//   CLK, RSTn        clock, asynchronous active-low reset
//   PUSH[3:0]        raw bar buttons: [1] bar1 left, [0] bar1 right, [3] bar2 left, [2] bar2 right
//   SERVE[1:0]       raw serve buttons: [0] player 1, [1] player 2
//   bar1_x, bar2_x   left cell of each bar
//   ball_x, ball_y   ball position
//   score1, score2   player scores
//   state            SERVE1=0, SERVE2=1, PLAY=2, POINT=3, OVER=4
//   led_code         {valid, type[1:0], y, x}; type 01 bar1, 10 bar2, 11 ball
module pong_engine #(
  parameter int X_W        = 3,
  parameter int Y_W        = 4,
  parameter int BAR_LEN    = 3,
  parameter int BAR1_Y     = 12,
  parameter int BAR2_Y     = 3,
  parameter int BAR_TICK   = 2000,
  parameter int BALL_TICK  = 4000000,
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 9,
  parameter int HOLD_TICKS = 4
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [3:0]             PUSH,
  input  logic [1:0]             SERVE,
  output logic [X_W-1:0]         bar1_x,
  output logic [X_W-1:0]         bar2_x,
  output logic [X_W-1:0]         ball_x,
  output logic [Y_W-1:0]         ball_y,
  output logic [SCORE_W-1:0]     score1,
  output logic [SCORE_W-1:0]     score2,
  output logic [2:0]             state,
  output logic [2+Y_W+X_W:0]     led_code
);
  localparam int BC_W = $clog2(BAR_TICK + 1);
  localparam int LC_W = $clog2(BALL_TICK + 1);
  localparam int HC_W = $clog2(HOLD_TICKS + 1);
  localparam int SL_W = $clog2(2 * BAR_LEN + 1);
  localparam logic [X_W-1:0]     HALF    = X_W'(BAR_LEN / 2);
  localparam logic [X_W-1:0]     MAXX    = X_W'((1 << X_W) - BAR_LEN);
  localparam logic [X_W-1:0]     LASTX   = X_W'((1 << X_W) - 1);
  localparam logic [X_W:0]       LEN1    = (X_W + 1)'(BAR_LEN - 1);
  localparam logic [Y_W-1:0]     Y1      = Y_W'(BAR1_Y);
  localparam logic [Y_W-1:0]     Y2      = Y_W'(BAR2_Y);
  localparam logic [Y_W-1:0]     Y1S     = Y_W'(BAR1_Y - 1);
  localparam logic [Y_W-1:0]     Y2S     = Y_W'(BAR2_Y + 1);
  localparam logic [SCORE_W-1:0] SMAX    = '1;
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [HC_W-1:0]    HLAST   = HC_W'(HOLD_TICKS - 1);
  localparam logic [SL_W-1:0]    SL_BAR2 = SL_W'(BAR_LEN);
  localparam logic [SL_W-1:0]    SL_BALL = SL_W'(2 * BAR_LEN);

  typedef enum logic [2:0] {
    S_SERVE1 = 3'd0,
    S_SERVE2 = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t               st, st_n;
  logic [BC_W-1:0]      bar_cnt;
  logic [LC_W-1:0]      ball_cnt;
  logic                 bar_tick, ball_tick;
  logic [3:0]           push_new, push_old, push_hit;
  logic [1:0]           serve_new, serve_old, serve_hit;
  logic                 up, up_n, lost1, lost1_n;
  logic [1:0]           dx, dx_n;
  logic [HC_W-1:0]      hold, hold_n;
  logic [X_W-1:0]       bar1_n, bar2_n, bx_n, def_x, off;
  logic [Y_W-1:0]       by_n, ny, def_y;
  logic [SCORE_W-1:0]   s1_n, s2_n;
  logic                 hit, miss, refl_l, refl_r;
  logic [SL_W-1:0]      slot;
  logic [2+Y_W+X_W:0]   code;

  assign state     = st;
  assign bar_tick  = bar_cnt == BC_W'(BAR_TICK - 1);
  assign ball_tick = ball_cnt == LC_W'(BALL_TICK - 1);
  assign push_hit  = {4{bar_tick}} & push_new & ~push_old;
  assign serve_hit = {2{bar_tick}} & serve_new & ~serve_old;

  // dx encoding: 00 = 0, 01 = +1, 11 = -1
  assign ny     = up ? ball_y + 1'b1 : ball_y - 1'b1;
  assign def_x  = up ? bar1_x : bar2_x;
  assign def_y  = up ? Y1 : Y2;
  assign off    = ball_x - def_x;
  assign miss   = up ? ball_y == Y1 : ball_y == Y2;
  // widened compare so a bar near the right edge cannot wrap
  assign hit    = ny == def_y && {1'b0, ball_x} >= {1'b0, def_x} && {1'b0, ball_x} <= {1'b0, def_x} + LEN1;
  assign refl_l = ball_x == '0 && dx == 2'b11;
  assign refl_r = ball_x == LASTX && dx == 2'b01;

  function automatic logic [X_W-1:0] step(input logic [X_W-1:0] x, input logic l, input logic r);
    return l ? (x == '0 ? x : x - 1'b1) : r ? (x == MAXX ? x : x + 1'b1) : x;
  endfunction

  function automatic logic [SCORE_W-1:0] inc_sat(input logic [SCORE_W-1:0] s);
    return s == SMAX ? s : s + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      bar_cnt   <= '0;
      ball_cnt  <= '0;
      push_new  <= '0;
      push_old  <= '0;
      serve_new <= '0;
      serve_old <= '0;
    end else begin
      bar_cnt  <= bar_tick ? '0 : bar_cnt + 1'b1;
      ball_cnt <= ball_tick ? '0 : ball_cnt + 1'b1;
      if (bar_tick) begin
        push_new  <= PUSH;
        push_old  <= push_new;
        serve_new <= SERVE;
        serve_old <= serve_new;
      end
    end

  always_comb begin
    st_n    = st;
    bar1_n  = bar1_x;
    bar2_n  = bar2_x;
    bx_n    = ball_x;
    by_n    = ball_y;
    up_n    = up;
    dx_n    = dx;
    s1_n    = score1;
    s2_n    = score2;
    hold_n  = hold;
    lost1_n = lost1;
    if (st != S_OVER) begin
      bar1_n = step(bar1_x, push_hit[1], push_hit[0]);
      bar2_n = step(bar2_x, push_hit[3], push_hit[2]);
    end
    unique case (st)
      S_SERVE1: begin
        bx_n = bar1_n + HALF;
        by_n = Y1S;
        if (serve_hit[0]) begin
          st_n = S_PLAY;
          up_n = 1'b0;
          dx_n = 2'b00;
        end
      end
      S_SERVE2: begin
        bx_n = bar2_n + HALF;
        by_n = Y2S;
        if (serve_hit[1]) begin
          st_n = S_PLAY;
          up_n = 1'b1;
          dx_n = 2'b00;
        end
      end
      S_PLAY: if (ball_tick) begin
        if (miss) begin
          st_n    = S_POINT;
          hold_n  = '0;
          lost1_n = up;
          s1_n    = up ? score1 : inc_sat(score1);
          s2_n    = up ? inc_sat(score2) : score2;
        end else if (hit) begin
          up_n = ~up;
          dx_n = off < HALF ? 2'b11 : off == HALF ? 2'b00 : 2'b01;
        end else begin
          by_n = ny;
          bx_n = refl_l ? X_W'(1) : refl_r ? LASTX - 1'b1 :
                 dx == 2'b01 ? ball_x + 1'b1 : dx == 2'b11 ? ball_x - 1'b1 : ball_x;
          dx_n = refl_l ? 2'b01 : refl_r ? 2'b11 : dx;
        end
      end
      S_POINT: if (ball_tick) begin
        if (hold == HLAST)
          st_n = (score1 >= WIN || score2 >= WIN) ? S_OVER : lost1 ? S_SERVE1 : S_SERVE2;
        else
          hold_n = hold + 1'b1;
      end
      S_OVER: if (|serve_hit) begin
        st_n   = S_SERVE1;
        s1_n   = '0;
        s2_n   = '0;
        bar1_n = '0;
        bar2_n = MAXX;
        bx_n   = HALF;
        by_n   = Y1S;
        up_n   = 1'b0;
        dx_n   = 2'b00;
      end
      default: st_n = S_SERVE1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      st     <= S_SERVE1;
      bar1_x <= '0;
      bar2_x <= MAXX;
      ball_x <= HALF;
      ball_y <= Y1S;
      up     <= 1'b0;
      dx     <= 2'b00;
      score1 <= '0;
      score2 <= '0;
      hold   <= '0;
      lost1  <= 1'b0;
    end else begin
      st     <= st_n;
      bar1_x <= bar1_n;
      bar2_x <= bar2_n;
      ball_x <= bx_n;
      ball_y <= by_n;
      up     <= up_n;
      dx     <= dx_n;
      score1 <= s1_n;
      score2 <= s2_n;
      hold   <= hold_n;
      lost1  <= lost1_n;
    end

  // ball slot is flagged invalid while the ball is frozen after a miss or at game end
  assign code = slot < SL_BAR2 ? {1'b1, 2'b01, Y1, bar1_x + X_W'(slot)} :
                slot < SL_BALL ? {1'b1, 2'b10, Y2, bar2_x + X_W'(slot - SL_BAR2)} :
                {!(st == S_OVER || st == S_POINT), 2'b11, ball_y, ball_x};

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      slot     <= '0;
      led_code <= '0;
    end else if (bar_tick) begin
      slot     <= slot == SL_BALL ? '0 : slot + 1'b1;
      led_code <= code;
    end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed self-checking bench for pong_engine with shortened tick periods
module tb_pong_engine;
  localparam int BT = 2;
  localparam int LT = 16;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [3:0] PUSH = '0;
  logic [1:0] SERVE = '0;
  logic [2:0] bar1_x, bar2_x, ball_x;
  logic [3:0] ball_y;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [9:0] led_code;

  int n_cmp = 0;
  int n_bad = 0;
  int bt = 0;
  int ba = 0;
  int sl = 0;

  pong_engine #(.BAR_TICK(BT), .BALL_TICK(LT)) dut (
    .CLK(CLK), .RSTn(RSTn), .PUSH(PUSH), .SERVE(SERVE),
    .bar1_x(bar1_x), .bar2_x(bar2_x), .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2), .state(state), .led_code(led_code)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      bt <= 0;
      ba <= 0;
      sl <= 0;
    end else begin
      bt <= bt == BT - 1 ? 0 : bt + 1;
      ba <= ba == LT - 1 ? 0 : ba + 1;
      if (bt == BT - 1) sl <= sl == 6 ? 0 : sl + 1;
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bar_edge();
    do @(negedge CLK); while (bt != BT - 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic ball_edge(input int n);
    repeat (n) begin
      do @(negedge CLK); while (ba != LT - 1);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic scan_to(input int s);
    do @(negedge CLK); while (!(bt == BT - 1 && sl == s));
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input int b);
    PUSH[b] = 1'b1;
    bar_edge();
    bar_edge();
    PUSH[b] = 1'b0;
    bar_edge();
    bar_edge();
  endtask

  task automatic serve(input int b);
    SERVE[b] = 1'b1;
    bar_edge();
    bar_edge();
    SERVE[b] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    PUSH = '0;
    SERVE = '0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 64) begin
      ball_edge(1);
      n++;
    end
    chk(tag, state, s);
  endtask

  initial begin
    do_reset();
    chk("rst_bar1", bar1_x, 0);
    chk("rst_bar2", bar2_x, 5);
    chk("rst_ball_x", ball_x, 1);
    chk("rst_ball_y", ball_y, 11);
    chk("rst_state", state, 0);
    chk("rst_score1", score1, 0);
    chk("rst_score2", score2, 0);
    chk("rst_led", led_code, 0);
    scan_to(0);
    chk("scan_bar1", led_code, {1'b1, 2'b01, 4'd12, 3'd0});
    scan_to(3);
    chk("scan_bar2", led_code, {1'b1, 2'b10, 4'd3, 3'd5});
    scan_to(6);
    chk("scan_ball", led_code, {1'b1, 2'b11, 4'd11, 3'd1});

    for (int i = 1; i <= 7; i++) begin
      press(0);
      chk("bar1_step", bar1_x, i > 5 ? 5 : i);
    end
    chk("track_ball_x", ball_x, 6);
    chk("track_state", state, 0);

    do_reset();
    chk("mid_rst_bar1", bar1_x, 0);
    repeat (2) press(0);
    repeat (3) press(3);
    chk("a_bar2", bar2_x, 2);
    chk("a_ball_x", ball_x, 3);
    serve(0);
    chk("a_play", state, 2);
    ball_edge(8);
    chk("a_hit_y", ball_y, 4);
    chk("a_hit_x", ball_x, 3);
    ball_edge(1);
    chk("a_up_y", ball_y, 5);
    chk("a_up_x", ball_x, 3);

    do_reset();
    press(0);
    repeat (3) press(3);
    serve(0);
    ball_edge(8);
    chk("b_hit_y", ball_y, 4);
    chk("b_hit_x", ball_x, 2);
    ball_edge(1);
    chk("b_t9", {ball_x, ball_y}, {3'd1, 4'd5});
    ball_edge(1);
    chk("b_t10", {ball_x, ball_y}, {3'd0, 4'd6});
    ball_edge(1);
    chk("b_wall_l", {ball_x, ball_y}, {3'd1, 4'd7});

    do_reset();
    repeat (3) press(0);
    repeat (3) press(3);
    serve(0);
    ball_edge(8);
    chk("c_hit", {ball_x, ball_y}, {3'd4, 4'd4});
    ball_edge(3);
    chk("c_t11", {ball_x, ball_y}, {3'd7, 4'd7});
    ball_edge(1);
    chk("c_wall_r", {ball_x, ball_y}, {3'd6, 4'd8});
    ball_edge(1);
    chk("c_t13", {ball_x, ball_y}, {3'd5, 4'd9});

    do_reset();
    serve(0);
    ball_edge(8);
    chk("d_row3_y", ball_y, 3);
    chk("d_row3_state", state, 2);
    ball_edge(1);
    chk("d_point", state, 3);
    chk("d_score1", score1, 1);
    chk("d_score2", score2, 0);
    chk("d_frozen_y", ball_y, 3);
    ball_edge(3);
    chk("d_hold", state, 3);
    ball_edge(1);
    chk("d_serve2", state, 1);
    bar_edge();
    chk("d_s2_ball", {ball_x, ball_y}, {3'd6, 4'd4});

    repeat (5) press(0);
    chk("e_bar1", bar1_x, 5);
    for (int i = 2; i <= 9; i++) begin
      repeat (3) press(2);
      serve(1);
      repeat (3) press(3);
      wait_state(3'd3, "e_point");
      chk("e_score1", score1, i);
      chk("e_score2", score2, 0);
      wait_state(i == 9 ? 3'd4 : 3'd1, "e_after");
    end

    press(1);
    press(2);
    chk("over_bar1", bar1_x, 5);
    chk("over_bar2", bar2_x, 2);
    chk("over_state", state, 4);
    scan_to(6);
    chk("over_scan_ball", led_code, {1'b0, 2'b11, 4'd3, 3'd6});
    serve(1);
    chk("new_state", state, 0);
    chk("new_score1", score1, 0);
    chk("new_score2", score2, 0);
    chk("new_bars", {bar1_x, bar2_x}, {3'd0, 3'd5});
    chk("new_ball", {ball_x, ball_y}, {3'd1, 4'd11});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
Parametrised two-player pong core for the LED-matrix board. It is the successor to the fixed 8x16 single-direction game. It adds diagonal ball motion, side-wall reflection, miss detection, scoring, serve/point/game-over sequencing, and a generic time-multiplexed object scan output. It sits between the push-button inputs and the LED matrix driver; the scores feed the 7-segment display block.

Parameters:
X_W, 3, column coordinate width; field width W = 2^X_W
Y_W, 4, row coordinate width; field height H = 2^Y_W
BAR_LEN, 3, bar length in cells; odd, 1..W-1
BAR1_Y, 12, row of bar 1; it defends the high-y side
BAR2_Y, 3, row of bar 2; it defends the low-y side; BAR2_Y < BAR1_Y
BAR_TICK, 2000, CLK cycles per bar/scan tick
BALL_TICK, 4000000, CLK cycles per ball tick
SCORE_W, 4, score width
WIN_SCORE, 9, score that ends the game
HOLD_TICKS, 4, ball ticks spent in POINT

Ports:
CLK  in  1  clock
RSTn  in  1  reset
PUSH  in  4  raw buttons: [1] bar1 left, [0] bar1 right, [3] bar2 left, [2] bar2 right
SERVE  in  2  raw serve buttons: [0] player 1, [1] player 2
bar1_x  out  X_W  left cell of bar 1
bar2_x  out  X_W  left cell of bar 2
ball_x  out  X_W  ball column
ball_y  out  Y_W  ball row
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
state  out  3  SERVE1=0, SERVE2=1, PLAY=2, POINT=3, OVER=4
led_code  out  3+Y_W+X_W  {valid, type[1:0], y, x}; type 01 = bar1, 10 = bar2, 11 = ball

Behaviour:
- Reset: RSTn, asynchronous, active-low; clock CLK. All registers reset asynchronously.
- Reset values:
  - bar1_x = 0; bar2_x = W-BAR_LEN.
  - ball_x = 0 + BAR_LEN/2; ball_y = BAR1_Y-1.
  - dir_y = toward bar 2 (decreasing y); dx = 0.
  - score1 = score2 = 0; state = SERVE1.
  - led_code = 0; both prescalers = 0; scan slot = 0.
- Prescalers:
  - bar_tick is a 1-cycle pulse when the bar counter equals BAR_TICK-1; the counter then wraps to 0.
  - ball_tick is the same scheme using BALL_TICK.
- Buttons:
  - PUSH and SERVE are sampled into 2-stage registers on bar_tick only.
  - A press is sampled pattern 01 (old=0, new=1), so at most one press per button per bar_tick.
- Bars:
  - On a press, the bar moves 1 cell and saturates at 0 and at W-BAR_LEN.
  - Left has priority over right when both are pressed on the same tick.
  - Bars move in SERVE1, SERVE2, PLAY and POINT; they are frozen in OVER.
- SERVE1:
  - ball_x = bar1_x + BAR_LEN/2 and ball_y = BAR1_Y-1 every cycle; the ball tracks the bar.
  - A SERVE[0] press -> PLAY, with dir_y toward bar 2 and dx = 0.
- SERVE2: mirror of SERVE1 using bar2_x, BAR2_Y+1 and SERVE[1].
- PLAY, evaluated on each ball_tick in this order:
  1. Miss: if ball_y == BAR1_Y moving +y, or ball_y == BAR2_Y moving -y -> POINT. The opposing player's score increments, saturating at 2^SCORE_W-1.
  2. Paddle hit: if the next row ny equals the defending bar row and ball_x is within [bar_x, bar_x+BAR_LEN-1]:
     - dir_y flips and ball_y is unchanged.
     - dx is set from offset = ball_x-bar_x: offset < BAR_LEN/2 -> -1; offset == BAR_LEN/2 -> 0; offset > BAR_LEN/2 -> +1.
     - ball_x does not move on this tick.
     - The range check uses X_W+1-bit arithmetic, so there is no wrap.
  3. Otherwise ball_y += dy. For x:
     - if ball_x == 0 and dx == -1, or ball_x == W-1 and dx == +1: dx negates and ball_x moves 1 cell the other way (reflection in the same tick).
     - else ball_x += dx.
  - ball_y never leaves [BAR2_Y, BAR1_Y].
- POINT:
  - The ball is frozen and a hold counter counts HOLD_TICKS ball_ticks.
  - At expiry, if either score >= WIN_SCORE -> OVER.
  - Otherwise the player who lost the point serves: SERVE1 if player 1 missed, else SERVE2.
- OVER:
  - Frozen.
  - Any SERVE press clears the scores and restores the reset positions -> SERVE1.
- Scan:
  - On each bar_tick the scan slot advances 0..2*BAR_LEN and wraps to 0.
  - Slots 0..BAR_LEN-1 show bar 1 cell (bar1_x+slot, BAR1_Y).
  - Slots BAR_LEN..2*BAR_LEN-1 show bar 2 cells.
  - Slot 2*BAR_LEN shows the ball; valid = 0 for this slot in OVER and during POINT.
  - led_code is registered and updates 1 cycle after bar_tick.
- Simultaneous events:
  - A bar move and a ball_tick in the same cycle: the hit check uses pre-move bar_x.
  - Miss is checked before hit.
  - Reset mid-game restores all reset values immediately.

Test Plan:
- Reset, no presses -> bar1_x=0, bar2_x=5, ball=(1,11), state=0, scores 0, led_code slot 0 = {1,01,12,0}.
- 7 PUSH[0] presses on separate bar_ticks -> bar1_x steps 1..5 then stays 5; ball_x tracks 6 in SERVE1.
- Serve with bar2_x=2 and the ball arriving at x=3 (bar middle) -> ball_y stays 4, dir_y flips, dx=0; arriving at x=2 -> dx=-1; arriving at x=4 -> dx=+1.
- dx=+1 with the ball at x=7 on a ball_tick -> ball_x=6, dx=-1 in the same tick.
- Bar 2 moved away and the ball passes row 3 -> next ball_tick gives state=POINT, score1=1; after 4 ball_ticks state=SERVE2.
- score1 reaches 9 -> POINT then OVER; bars ignore PUSH; SERVE[1] press -> scores 0, state SERVE1.
